// File: rtl/mips_instr_encoder.sv
// Encodes MIPS instruction requests into 32-bit words, buffers them with their
// instruction-memory addresses and streams them out. Optional macro: MIPS_ENCODER_DELAY_SLOT_EN.
module mips_instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [15:0] words_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ORI = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_SW  = 4'd4;
    localparam logic [3:0] OP_BEQ = 4'd5;
    localparam logic [3:0] OP_LUI = 4'd6;
    localparam logic [3:0] OP_J   = 4'd7;
    localparam logic [3:0] OP_JAL = 4'd8;
    localparam logic [3:0] OP_JR  = 4'd9;
    localparam logic [3:0] OP_NOP = 4'd10;

    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_addr_q  [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;
    logic [15:0]   words_q, words_d;
    logic [31:0]   last_instr_q, last_instr_d;
    logic [31:0]   last_addr_q, last_addr_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept;
    logic          push;
    logic          push_slot;
    logic          pop;
    logic [CW-1:0] n_push;
    logic [31:0]   addr_step;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (req_op)
            OP_ADD:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
            OP_SUB:  enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
            OP_ORI:  enc_word = {6'b001101, req_rs, req_rt, req_imm};
            OP_LW:   enc_word = {6'b100011, req_rs, req_rt, req_imm};
            OP_SW:   enc_word = {6'b101011, req_rs, req_rt, req_imm};
            OP_BEQ:  enc_word = {6'b000100, req_rs, req_rt, req_imm};
            OP_LUI:  enc_word = {6'b001111, 5'b00000, req_rt, req_imm};
            OP_J:    enc_word = {6'b000010, req_target};
            OP_JAL:  enc_word = {6'b000011, req_target};
            OP_JR:   enc_word = {6'b000000, req_rs, 15'b0, 6'b001000};
            OP_NOP:  enc_word = 32'h0;
            default: enc_legal = 1'b0;
        endcase
    end

    // Handshakes: a request transfers when req_valid && req_ready, a word when
    // out_valid && out_ready; ready never looks at the op or at out_ready.
`ifdef MIPS_ENCODER_DELAY_SLOT_EN
    assign req_ready = !clear && (count_q <= DEPTH_C - CW'(2));
    assign push_slot = push && (req_op == OP_BEQ || req_op == OP_J ||
                                req_op == OP_JAL || req_op == OP_JR);
`else
    assign req_ready = !clear && (count_q < DEPTH_C);
    assign push_slot = 1'b0;
`endif

    assign accept    = req_valid && req_ready;
    assign push      = accept && enc_legal;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !clear;
    assign n_push    = push ? (push_slot ? CW'(2) : CW'(1)) : '0;
    assign addr_step = push ? (push_slot ? 32'd8 : 32'd4) : 32'd0;

    // When empty the outputs show the last word that left (or was flushed).
    assign out_instr   = out_valid ? mem_instr_q[rd_ptr_q] : last_instr_q;
    assign out_addr    = out_valid ? mem_addr_q[rd_ptr_q]  : last_addr_q;
    assign err_illegal = err_q;
    assign words_out   = words_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        addr_d       = addr_q;
        err_d        = 1'b0;
        words_d      = words_q;
        last_instr_d = last_instr_q;
        last_addr_d  = last_addr_q;
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            addr_d       = BASE_ADDR;
            last_instr_d = out_instr;
            last_addr_d  = out_addr;
        end else begin
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                words_d      = words_q + 16'd1;
                last_instr_d = out_instr;
                last_addr_d  = out_addr;
            end
            wr_ptr_d = wr_ptr_q + n_push[AW-1:0];
            count_d  = count_q + n_push - CW'(pop);
            addr_d   = addr_q + addr_step;
            err_d    = accept && !enc_legal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= BASE_ADDR;
            err_q        <= 1'b0;
            words_q      <= 16'd0;
            last_instr_q <= 32'h0;
            last_addr_q  <= BASE_ADDR;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            words_q      <= words_d;
            last_instr_q <= last_instr_d;
            last_addr_q  <= last_addr_d;
        end
    end

    // Storage needs no reset: pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= enc_word;
            mem_addr_q[wr_ptr_q]  <= addr_q;
        end
        if (push_slot) begin
            mem_instr_q[wr_ptr_q + AW'(1)] <= 32'h0;
            mem_addr_q[wr_ptr_q + AW'(1)]  <= addr_q + 32'd4;
        end
    end

endmodule
